ppu_vram_resp: RTL

//  Responder side of the PPU VRAM fetch port: services 14-bit reads from the background/sprite fetchers.

---
 rtl/ppu_vram_resp.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/ppu_vram_resp.sv
// ppu_vram_resp: responder side of the PPU VRAM fetch port.
//   Holds the 2 KiB nametable RAM (CIRAM) and the 32-entry x 6-bit palette
//   RAM. Pattern-table addresses ($0000-$1FFF) are forwarded to cartridge CHR.
//   A single CPU ($2007) access is serviced in cycles where the PPU fetch port
//   is idle; the PPU port always wins.
//
// Ports
//   clk_in, rst_in        clock, synchronous active-low reset
//   mirror_in             0=horizontal 1=vertical 2=single low 3=single high
//   ppu_en_in/addr_in     fetch request; ppu_data_out/ppu_valid_out one cycle later
//   cpu_req_in/we/addr/wdata  CPU access request (pulse)
//   cpu_rdata_out/ack/busy    CPU response, ack pulse, pending indicator
//   chr_addr_out/en/data_in   CHR read port (data one cycle after en)
//   chr_we_out/wdata_out      CHR write port (CHR RAM builds only)
//
// Configuration
//   CHR_RAM_EN  when defined, CPU writes to $0000-$1FFF are forwarded to CHR;
//               otherwise they are dropped (still acknowledged).

module ppu_vram_resp #(
    parameter int CIRAM_AW = 11,
    parameter int PAL_AW   = 5
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [1:0]  mirror_in,
    input  logic        ppu_en_in,
    input  logic [13:0] ppu_addr_in,
    output logic [7:0]  ppu_data_out,
    output logic        ppu_valid_out,
    input  logic        cpu_req_in,
    input  logic        cpu_we_in,
    input  logic [13:0] cpu_addr_in,
    input  logic [7:0]  cpu_wdata_in,
    output logic [7:0]  cpu_rdata_out,
    output logic        cpu_ack_out,
    output logic        cpu_busy_out,
    output logic [12:0] chr_addr_out,
    output logic        chr_en_out,
    input  logic [7:0]  chr_data_in,
    output logic        chr_we_out,
    output logic [7:0]  chr_wdata_out
);

    localparam int NT_BITS = CIRAM_AW - 1;

    typedef enum logic [1:0] {ST_IDLE, ST_PEND, ST_DATA} cpu_state_e;
    typedef enum logic [1:0] {RG_CHR, RG_CIRAM, RG_PAL} region_e;

    cpu_state_e state_q, state_d;
    logic       latch_en;
    logic       cpu_we_q;
    logic [13:0] cpu_addr_q;
    logic [7:0] cpu_wdata_q;
    logic [7:0] cpu_rdata_q;

    logic       ppu_valid_q;
    logic [7:0] ppu_hold_q;
    region_e    region_q;
    logic [7:0] rd_q;

    logic [7:0] ciram_mem [2**CIRAM_AW];
    logic [5:0] pal_mem   [2**PAL_AW];

    // Shared access slot: the PPU owns it whenever it asks; a pending CPU
    // access only gets it in a cycle the PPU leaves free.
    logic        ppu_grant, cpu_grant, acc_en;
    logic [13:0] acc_addr;
    region_e     acc_region;
    logic        bank;
    logic [CIRAM_AW-1:0] ciram_idx;
    logic [PAL_AW-1:0]   pal_idx;
    logic [7:0]  resp_data;

    assign ppu_grant = rst_in && ppu_en_in;
    assign cpu_grant = rst_in && !ppu_en_in && (state_q == ST_PEND);
    assign acc_en    = ppu_grant || cpu_grant;
    assign acc_addr  = ppu_en_in ? ppu_addr_in : cpu_addr_q;

    // NOTE: every signal written in an always_comb gets a default first, so no
    // path through the block leaves it unassigned and no latch is inferred.
    always_comb begin
        acc_region = RG_CHR;
        bank       = 1'b0;
        ciram_idx  = '0;
        pal_idx    = '0;
        if (acc_addr[13]) begin
            if (acc_addr[13:8] == 6'h3F) begin
                acc_region = RG_PAL;
                pal_idx    = acc_addr[PAL_AW-1:0];
                // $3F10/14/18/1C are mirrors of $3F00/04/08/0C.
                if (pal_idx[PAL_AW-1] && (pal_idx[1:0] == 2'b00))
                    pal_idx[PAL_AW-1] = 1'b0;
            end else begin
                acc_region = RG_CIRAM;
                case (mirror_in)
                    2'd0:    bank = acc_addr[11];
                    2'd1:    bank = acc_addr[10];
                    2'd2:    bank = 1'b0;
                    default: bank = 1'b1;
                endcase
                ciram_idx = {bank, acc_addr[NT_BITS-1:0]};
            end
        end
    end

    // NOTE: the RAM arrays are deliberately outside the reset branch; their
    // contents are undefined after reset and resetting them would prevent
    // mapping onto block RAM.
    always_ff @(posedge clk_in) begin
        if (cpu_grant && cpu_we_q) begin
            if (acc_region == RG_CIRAM) ciram_mem[ciram_idx] <= cpu_wdata_q;
            if (acc_region == RG_PAL)   pal_mem[pal_idx]     <= cpu_wdata_q[5:0];
        end
        if (acc_en) begin
            rd_q <= (acc_region == RG_PAL) ? {2'b00, pal_mem[pal_idx]} : ciram_mem[ciram_idx];
        end
    end

    // Response data for the access granted in the previous cycle; CHR data
    // arrives from the cartridge exactly then.
    assign resp_data = (region_q == RG_CHR) ? chr_data_in : rd_q;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples values from before the clock edge, independent of block order.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            ppu_valid_q <= 1'b0;
            ppu_hold_q  <= 8'h00;
            region_q    <= RG_CHR;
        end else begin
            ppu_valid_q <= ppu_grant;
            if (ppu_valid_q) ppu_hold_q <= resp_data;
            if (acc_en)      region_q   <= acc_region;
        end
    end

    assign ppu_valid_out = ppu_valid_q;
    assign ppu_data_out  = ppu_valid_q ? resp_data : ppu_hold_q;

    // CPU request FSM. DATA doubles as an idle cycle, so a request arriving
    // together with the ack is accepted.
    always_comb begin
        state_d  = state_q;
        latch_en = 1'b0;
        case (state_q)
            ST_IDLE: if (cpu_req_in) begin
                state_d  = ST_PEND;
                latch_en = 1'b1;
            end
            ST_PEND: if (!ppu_en_in) state_d = ST_DATA;
            ST_DATA: if (cpu_req_in) begin
                state_d  = ST_PEND;
                latch_en = 1'b1;
            end else begin
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state_q     <= ST_IDLE;
            cpu_we_q    <= 1'b0;
            cpu_addr_q  <= '0;
            cpu_wdata_q <= 8'h00;
            cpu_rdata_q <= 8'h00;
        end else begin
            state_q <= state_d;
            if (latch_en) begin
                cpu_we_q    <= cpu_we_in;
                cpu_addr_q  <= cpu_addr_in;
                cpu_wdata_q <= cpu_wdata_in;
            end
            if ((state_q == ST_DATA) && !cpu_we_q) cpu_rdata_q <= resp_data;
        end
    end

    assign cpu_ack_out   = (state_q == ST_DATA);
    assign cpu_busy_out  = (state_q == ST_PEND);
    assign cpu_rdata_out = ((state_q == ST_DATA) && !cpu_we_q) ? resp_data : cpu_rdata_q;

    assign chr_en_out   = acc_en && (acc_region == RG_CHR);
    assign chr_addr_out = chr_en_out ? acc_addr[12:0] : 13'h0000;

`ifdef CHR_RAM_EN
    assign chr_we_out    = cpu_grant && cpu_we_q && (acc_region == RG_CHR);
    assign chr_wdata_out = chr_we_out ? cpu_wdata_q : 8'h00;
`else
    assign chr_we_out    = 1'b0;
    assign chr_wdata_out = 8'h00;
`endif

endmodule
